guvm_mem_responder: RTL
=======================

Name: guvm_mem_responder

Overview:
Synthesizable memory-side responder that replaces hand-toggled instruction/data stimulus for the RISCY core. Sits between the testbench and the core's OBI-style instruction and data ports: the testbench queues instructions and load data into FIFOs; the block answers core req/gnt/rvalid handshakes with configurable response latency and captures every store into a FIFO for the scoreboard. Successor to fixed-timing task-driven stimulus: adds depth, latency and empty-policy parameters plus real handshakes.

Parameters:
INSTR_DEPTH, 16, instruction FIFO entries (power of 2, >=2)
LOAD_DEPTH, 8, load-data FIFO entries (power of 2, >=2)
STORE_DEPTH, 8, store-capture FIFO entries (power of 2, >=2)
RVALID_LAT, 1, cycles from grant to rvalid, legal 1..4; other values -> elaboration $error
EMPTY_NOP, 0, 1: empty instruction FIFO answers with NOP_INSTR instead of stalling
NOP_INSTR, 32'h00000013, instruction returned when EMPTY_NOP=1 and FIFO empty

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_ni  in  1  synchronous active-low reset
tb_inst_valid_i / tb_inst_i / tb_inst_ready_o  in/in/out  1/32/1  instruction push; ready = instruction FIFO not full
tb_ld_valid_i / tb_ld_data_i / tb_ld_ready_o  in/in/out  1/32/1  load-data push; ready = load FIFO not full
tb_st_valid_o / tb_st_ready_i  out/in  1/1  store-record pop; valid = store FIFO not empty
tb_st_addr_o / tb_st_data_o / tb_st_be_o  out  32/32/4  head store record (addr, wdata, be)
instr_req_i / instr_addr_i  in  1/32  core fetch request, address (address recorded only)
instr_gnt_o / instr_rvalid_o / instr_rdata_o  out  1/1/32  fetch grant, response valid, instruction
data_req_i / data_we_i / data_be_i  in  1/1/4  core data request, write enable, byte enables
data_addr_i / data_wdata_i  in  32/32  data address, write data
data_gnt_o / data_rvalid_o / data_rdata_o  out  1/1/32  data grant, response valid, load data
inst_cnt_o  out  32  instructions delivered (rvalid count), wraps at 2^32
last_fetch_addr_o  out  32  instr_addr_i of last granted fetch

Behaviour:
- Reset (rst_ni=0 at edge): all FIFOs empty, pipelines cleared, pending flags 0, inst_cnt_o=0, last_fetch_addr_o=0; all gnt/rvalid/tb_st_valid_o low, rdata outputs 0. In-flight responses dropped, no rvalid after reset.
- One outstanding transaction per channel; channels independent, may grant in the same cycle.
- instr_gnt_o (combinational) = instr_req_i & ~instr_busy & (inst FIFO non-empty | EMPTY_NOP). If EMPTY_NOP=0 and FIFO empty: gnt low, core stalls.
- data_gnt_o = data_req_i & ~data_busy & (data_we_i ? store FIFO not full : load FIFO non-empty).
- On grant: FIFO head popped (or NOP substituted, nothing popped) into a RVALID_LAT-stage shift register; busy set. rvalid high for exactly one cycle, RVALID_LAT cycles after grant edge; rdata valid only that cycle, else held at last value. busy clears in rvalid cycle, so a new grant is allowed in that cycle (max throughput 1 per RVALID_LAT cycles).
- Store grant: {addr, wdata, be} pushed to store FIFO at grant edge; data_rvalid_o follows with data_rdata_o=0.
- inst_cnt_o increments on each instr_rvalid_o, NOP responses included.
- FIFOs: no bypass; ready/valid reflect registered occupancy. Push when full ignored (ready low). Simultaneous push and pop at same FIFO legal, occupancy unchanged. Pointers wrap modulo depth; full/empty via extra pointer bit.
- req dropping while not granted is legal; req after grant is not sampled until busy clears.

Test Plan:
- Reset, push 3 instrs 0x00100093,0x00200113,0x002081B3, hold instr_req_i, RVALID_LAT=1 -> gnt on cycles 0,1,2 after first; rvalid one cycle later each, rdata in push order; inst_cnt_o=3.
- RVALID_LAT=3, one fetch -> rvalid exactly 3 cycles after gnt; second gnt no earlier than rvalid cycle.
- EMPTY_NOP=0, empty FIFO, req high 10 cycles -> gnt stays low; push 0x00000013 -> gnt next cycle. EMPTY_NOP=1 -> immediate gnt, rdata 0x00000013, FIFO untouched.
- Store addr 0x100, wdata 0xDEADBEEF, be 4'hF; then load with 0x12345678 queued -> tb_st record matches, store rdata 0, load rdata 0x12345678.
- Fill store FIFO (8 stores, tb_st_ready_i=0) -> 9th store gnt low; pop one -> gnt next cycle; simultaneous push/pop keeps occupancy.
- Assert rst_ni=0 between grant and rvalid with RVALID_LAT=4 -> no rvalid, all FIFOs empty, inst_cnt_o=0.

Source files
------------

// File: rtl/guvm_mem_responder.sv
// Memory-side responder for the RISCY core's OBI-style instruction and data ports.
// The testbench queues instructions and load data into FIFOs. This block answers
// core req/gnt/rvalid handshakes with a fixed response latency and captures every
// store into a FIFO, where the scoreboard can pop it.

// Synchronous FIFO with registered occupancy and no bypass.
// Full and empty are told apart by one extra pointer bit.
module guvm_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    // Pointers advance independently, so a simultaneous push and pop keeps occupancy unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // The storage array needs no reset: nothing reads it while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// Fixed-latency response pipeline for one channel with one outstanding transaction.
// A grant enters stage 0. rvalid appears LAT cycles later, on the last stage.
// Each stage loads data only when a valid enters it. The output data therefore
// holds the previous response until the next rvalid.
module guvm_resp_pipe #(
    parameter int WIDTH = 32,
    parameter int LAT   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             gnt,
    input  logic [WIDTH-1:0] gnt_data,
    output logic             rvalid,
    output logic [WIDTH-1:0] rdata,
    output logic             busy
);

    logic [LAT-1:0]   vld;
    logic [WIDTH-1:0] dat [LAT];
    logic             pending;

    assign rvalid = vld[LAT-1];
    assign rdata  = dat[LAT-1];
    // The channel frees up in the rvalid cycle, so back-to-back grants are possible.
    assign busy   = pending & ~rvalid;

    // Shift the response toward rvalid. Reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld <= '0;
            for (int i = 0; i < LAT; i++) begin
                dat[i] <= '0;
            end
        end else begin
            vld[0] <= gnt;
            if (gnt) begin
                dat[0] <= gnt_data;
            end
            for (int i = 1; i < LAT; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) begin
                    dat[i] <= dat[i-1];
                end
            end
        end
    end

    // Track the one outstanding transaction from grant until its rvalid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= 1'b0;
        end else if (gnt) begin
            pending <= 1'b1;
        end else if (rvalid) begin
            pending <= 1'b0;
        end
    end

endmodule

// Top level: instruction, load-data and store-capture FIFOs plus two response pipelines.
module guvm_mem_responder #(
    parameter int          INSTR_DEPTH = 16,
    parameter int          LOAD_DEPTH  = 8,
    parameter int          STORE_DEPTH = 8,
    parameter int          RVALID_LAT  = 1,
    parameter int          EMPTY_NOP   = 0,
    parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        tb_inst_valid_i,
    input  logic [31:0] tb_inst_i,
    output logic        tb_inst_ready_o,
    input  logic        tb_ld_valid_i,
    input  logic [31:0] tb_ld_data_i,
    output logic        tb_ld_ready_o,
    output logic        tb_st_valid_o,
    input  logic        tb_st_ready_i,
    output logic [31:0] tb_st_addr_o,
    output logic [31:0] tb_st_data_o,
    output logic [3:0]  tb_st_be_o,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic [31:0] inst_cnt_o,
    output logic [31:0] last_fetch_addr_o
);

    // An illegal latency is clamped so that the array sizes stay sane after the error.
    localparam int LAT_EFF = (RVALID_LAT < 1) ? 1 : ((RVALID_LAT > 4) ? 4 : RVALID_LAT);

    if ((RVALID_LAT < 1) || (RVALID_LAT > 4)) begin : g_bad_lat
        $error("guvm_mem_responder: RVALID_LAT must be in 1..4");
    end
    if ((INSTR_DEPTH < 2) || ((INSTR_DEPTH & (INSTR_DEPTH - 1)) != 0)) begin : g_bad_idepth
        $error("guvm_mem_responder: INSTR_DEPTH must be a power of 2 and >= 2");
    end
    if ((LOAD_DEPTH < 2) || ((LOAD_DEPTH & (LOAD_DEPTH - 1)) != 0)) begin : g_bad_ldepth
        $error("guvm_mem_responder: LOAD_DEPTH must be a power of 2 and >= 2");
    end
    if ((STORE_DEPTH < 2) || ((STORE_DEPTH & (STORE_DEPTH - 1)) != 0)) begin : g_bad_sdepth
        $error("guvm_mem_responder: STORE_DEPTH must be a power of 2 and >= 2");
    end

    logic        nop_en;
    logic        inst_full;
    logic        inst_empty;
    logic [31:0] inst_head;
    logic        inst_pop;
    logic        instr_busy;
    logic [31:0] instr_resp;

    logic        ld_full;
    logic        ld_empty;
    logic [31:0] ld_head;
    logic        ld_pop;

    logic        st_full;
    logic        st_empty;
    logic [67:0] st_head;
    logic        st_push;

    logic        data_busy;
    logic [31:0] data_resp;

    assign nop_en = (EMPTY_NOP != 0);

    // Instruction channel: stall on an empty FIFO unless NOP substitution is enabled.
    assign instr_gnt_o = rst_ni & instr_req_i & ~instr_busy & (~inst_empty | nop_en);
    assign inst_pop    = instr_gnt_o & ~inst_empty;
    assign instr_resp  = inst_empty ? NOP_INSTR : inst_head;

    // Data channel: a store needs room to be captured; a load needs queued data.
    assign data_gnt_o = rst_ni & data_req_i & ~data_busy & (data_we_i ? ~st_full : ~ld_empty);
    assign st_push    = data_gnt_o & data_we_i;
    assign ld_pop     = data_gnt_o & ~data_we_i;
    assign data_resp  = data_we_i ? 32'h0 : ld_head;

    assign tb_inst_ready_o = ~inst_full;
    assign tb_ld_ready_o   = ~ld_full;
    assign tb_st_valid_o   = ~st_empty;
    assign tb_st_addr_o    = st_head[67:36];
    assign tb_st_data_o    = st_head[35:4];
    assign tb_st_be_o      = st_head[3:0];

    guvm_fifo #(.WIDTH(32), .DEPTH(INSTR_DEPTH)) u_inst_fifo (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .push      (tb_inst_valid_i),
        .push_data (tb_inst_i),
        .pop       (inst_pop),
        .head      (inst_head),
        .full      (inst_full),
        .empty     (inst_empty)
    );

    guvm_fifo #(.WIDTH(32), .DEPTH(LOAD_DEPTH)) u_ld_fifo (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .push      (tb_ld_valid_i),
        .push_data (tb_ld_data_i),
        .pop       (ld_pop),
        .head      (ld_head),
        .full      (ld_full),
        .empty     (ld_empty)
    );

    guvm_fifo #(.WIDTH(68), .DEPTH(STORE_DEPTH)) u_st_fifo (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .push      (st_push),
        .push_data ({data_addr_i, data_wdata_i, data_be_i}),
        .pop       (tb_st_ready_i),
        .head      (st_head),
        .full      (st_full),
        .empty     (st_empty)
    );

    guvm_resp_pipe #(.WIDTH(32), .LAT(LAT_EFF)) u_instr_pipe (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .gnt      (instr_gnt_o),
        .gnt_data (instr_resp),
        .rvalid   (instr_rvalid_o),
        .rdata    (instr_rdata_o),
        .busy     (instr_busy)
    );

    guvm_resp_pipe #(.WIDTH(32), .LAT(LAT_EFF)) u_data_pipe (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .gnt      (data_gnt_o),
        .gnt_data (data_resp),
        .rvalid   (data_rvalid_o),
        .rdata    (data_rdata_o),
        .busy     (data_busy)
    );

    // Count delivered instructions, NOPs included; the counter wraps naturally.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            inst_cnt_o <= 32'h0;
        end else if (instr_rvalid_o) begin
            inst_cnt_o <= inst_cnt_o + 32'd1;
        end
    end

    // Remember the address of the most recent granted fetch.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            last_fetch_addr_o <= 32'h0;
        end else if (instr_gnt_o) begin
            last_fetch_addr_o <= instr_addr_i;
        end
    end

endmodule
